// File: rtl/aardvark_pkg.sv
// Shared codes for the fetch sequencer: redirect kinds and FSM state encoding.
package aardvark_pkg;

  typedef enum logic [1:0] {
    REDIR_BRANCH = 2'd0,
    REDIR_JUMP   = 2'd1,
    REDIR_JAL    = 2'd2,
    REDIR_JR     = 2'd3
  } redir_kind_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StReq    = 2'd1,
    StHold   = 2'd2,
    StHalted = 2'd3
  } seq_state_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full silently overwrites the oldest entry.
module pc_ras #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PtrW-1:0]  top_idx;

  // ptr_q is the next free slot; wrapping it is what recycles the oldest entry.
  assign top_idx = ptr_q - PtrW'(1);
  assign top_o   = mem_q[top_idx];
  assign empty_o = (cnt_q == '0);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + PtrW'(1);
      if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (push_i) mem_q[ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch / next-PC sequencer: owns the PC, fetches over req/ack, hands words to decode.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer
  import aardvark_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned INST_W    = 8,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_out_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              redir_valid_i,
  input  logic [1:0]        redir_kind_i,
  input  logic [ADDR_W-1:0] redir_offset_i,
  input  logic [ADDR_W-1:0] redir_reg_i,
  output logic              link_we_o,
  output logic [ADDR_W-1:0] link_addr_o,
  input  logic              halt_i,
  output logic              halted_o
);

  localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              link_we_q, link_we_d;
  logic [ADDR_W-1:0] link_addr_q, link_addr_d;

  redir_kind_e       kind;
  logic              xfer;
  logic              redir;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] jr_target;

  assign kind   = redir_kind_e'(redir_kind_i);
  assign xfer   = (state_q == StHold) && inst_ready_i;
  assign redir  = xfer && redir_valid_i;
  assign seq_pc = inst_pc_q + ADDR_W'(1);

`ifdef PC_RAS_EN
  logic              ras_push;
  logic              ras_pop;
  logic              ras_empty;
  logic [ADDR_W-1:0] ras_top;

  assign ras_push = redir && (kind == REDIR_JAL);
  assign ras_pop  = redir && (kind == REDIR_JR);

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ras (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (seq_pc),
    .top_o   (ras_top),
    .empty_o (ras_empty)
  );

  assign jr_target = ras_empty ? redir_reg_i : ras_top;
`else
  assign jr_target = redir_reg_i;
`endif

  always_comb begin
    next_pc = seq_pc;
    if (redir_valid_i) begin
      unique case (kind)
        REDIR_BRANCH, REDIR_JUMP, REDIR_JAL: next_pc = inst_pc_q + redir_offset_i;
        REDIR_JR:                            next_pc = jr_target;
        default:                             next_pc = seq_pc;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    link_we_d   = 1'b0;
    link_addr_d = link_addr_q;
    unique case (state_q)
      StIdle: state_d = halt_i ? StHalted : StReq;
      StReq: begin
        if (imem_ack_i) begin
          // A halt here drops the fetched word; the same pc is refetched on release.
          if (halt_i) begin
            state_d = StHalted;
          end else begin
            inst_d    = imem_rdata_i;
            inst_pc_d = pc_q;
            state_d   = StHold;
          end
        end
      end
      StHold: begin
        if (xfer) begin
          pc_d    = next_pc;
          state_d = StReq;
          if (redir && (kind == REDIR_JAL)) begin
            link_we_d   = 1'b1;
            link_addr_d = seq_pc;
          end
        end
        if (halt_i) state_d = StHalted;
      end
      StHalted: if (!halt_i) state_d = StReq;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      pc_q        <= ResetPc;
      inst_q      <= '0;
      inst_pc_q   <= '0;
      link_we_q   <= 1'b0;
      link_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      link_we_q   <= link_we_d;
      link_addr_q <= link_addr_d;
    end
  end

  assign imem_req_o   = (state_q == StReq);
  assign imem_addr_o  = pc_q;
  assign inst_valid_o = (state_q == StHold);
  assign inst_out_o   = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign link_we_o    = link_we_q;
  assign link_addr_o  = link_addr_q;
  assign halted_o     = (state_q == StHalted);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized fetch/redirect traffic.
module tb_pc_sequencer;

  localparam int RasDepth = 4;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       imem_req, imem_ack = 1'b0;
  logic [7:0] imem_addr, imem_rdata = '0;
  logic       inst_valid, inst_ready = 1'b0;
  logic [7:0] inst_out, inst_pc;
  logic       redir_valid = 1'b0;
  logic [1:0] redir_kind = '0;
  logic [7:0] redir_offset = '0, redir_reg = '0;
  logic       link_we;
  logic [7:0] link_addr;
  logic       halt = 1'b0, halted;

  pc_sequencer #(
    .ADDR_W    (8),
    .INST_W    (8),
    .RESET_PC  (0),
    .RAS_DEPTH (RasDepth)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .imem_ack_i     (imem_ack),
    .imem_rdata_i   (imem_rdata),
    .inst_valid_o   (inst_valid),
    .inst_ready_i   (inst_ready),
    .inst_out_o     (inst_out),
    .inst_pc_o      (inst_pc),
    .redir_valid_i  (redir_valid),
    .redir_kind_i   (redir_kind),
    .redir_offset_i (redir_offset),
    .redir_reg_i    (redir_reg),
    .link_we_o      (link_we),
    .link_addr_o    (link_addr),
    .halt_i         (halt),
    .halted_o       (halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: architectural PC and return-address stack (newest at back).
  logic [7:0] m_pc;
  logic [7:0] m_ras[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_next(input bit rv, input logic [1:0] kind,
                                            input logic [7:0] off, input logic [7:0] rreg,
                                            input logic [7:0] pc);
    logic [7:0] tgt;
    if (!rv) return pc + 8'd1;
    if (kind == 2'd3) begin
      tgt = rreg;
`ifdef PC_RAS_EN
      if (m_ras.size() > 0) tgt = m_ras.pop_back();
`endif
      return tgt;
    end
`ifdef PC_RAS_EN
    if (kind == 2'd2) begin
      m_ras.push_back(pc + 8'd1);
      if (m_ras.size() > RasDepth) void'(m_ras.pop_front());
    end
`endif
    return pc + off;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    imem_ack = 0; inst_ready = 0; redir_valid = 0; halt = 0;
    #2 rst_ni = 1'b0;
    #1;
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_addr", imem_addr, 0);
    check_eq("rst_valid", inst_valid, 0);
    check_eq("rst_inst", {inst_out, inst_pc}, 0);
    check_eq("rst_link", {link_we, link_addr}, 0);
    check_eq("rst_halted", halted, 0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    check_eq("idle_req", imem_req, 0);
    m_pc = 8'h00;
    m_ras.delete();
  endtask

  task automatic wait_req();
    int guard = 0;
    while (imem_req !== 1'b1 && guard < 10) begin
      step();
      guard++;
    end
    check_eq("req_seen", imem_req, 1);
  endtask

  // One full fetch + transfer; afterwards the model PC holds the expected next fetch address.
  task automatic xact(input int ack_dly, input int rdy_dly, input bit rv, input logic [1:0] kind,
                      input logic [7:0] off, input logic [7:0] rreg);
    logic [7:0] data;
    logic [7:0] ipc;
    bit         exp_link;
    wait_req();
    check_eq("imem_addr", imem_addr, m_pc);
    for (int i = 0; i < ack_dly; i++) begin
      step();
      check_eq("req_held", {imem_req, inst_valid}, 2'b10);
      check_eq("addr_stable", imem_addr, m_pc);
    end
    data = 8'($urandom);
    imem_ack = 1; imem_rdata = data;
    step();
    imem_ack = 0; imem_rdata = 8'($urandom);
    check_eq("hold_valid", {inst_valid, imem_req}, 2'b10);
    check_eq("inst_out", inst_out, data);
    check_eq("inst_pc", inst_pc, m_pc);
    check_eq("link_pulse_end", link_we, 0);
    for (int i = 0; i < rdy_dly; i++) begin
      step();
      check_eq("hold_stable", {inst_valid, inst_out, inst_pc}, {1'b1, data, m_pc});
    end
    inst_ready = 1; redir_valid = rv; redir_kind = kind; redir_offset = off; redir_reg = rreg;
    step();
    inst_ready = 0; redir_valid = 0; redir_kind = 2'($urandom); redir_offset = 8'($urandom);
    ipc      = m_pc;
    exp_link = rv && (kind == 2'd2);
    m_pc     = model_next(rv, kind, off, rreg, ipc);
    check_eq("link_we", link_we, exp_link);
    if (exp_link) check_eq("link_addr", link_addr, ipc + 8'd1);
    check_eq("next_req", {imem_req, inst_valid}, 2'b10);
    check_eq("next_addr", imem_addr, m_pc);
  endtask

  task automatic halt_in_req();
    wait_req();
    halt = 1;
    step();
    imem_ack = 1;
    step();
    imem_ack = 0;
    check_eq("halt_req_state", {halted, inst_valid, imem_req}, 3'b100);
    step();
    check_eq("halt_parked", halted, 1);
    halt = 0;
    step();
    check_eq("halt_release", {halted, imem_req}, 2'b01);
    check_eq("refetch_addr", imem_addr, m_pc);
  endtask

  task automatic halt_in_hold();
    wait_req();
    imem_ack = 1;
    step();
    imem_ack = 0;
    halt = 1;
    step();
    check_eq("hold_halt", {halted, inst_valid, imem_req}, 3'b100);
    halt = 0;
    step();
    check_eq("hold_refetch", {imem_req, imem_addr}, {1'b1, m_pc});
  endtask

  logic [7:0] exp_jr [5];

  initial begin
    // 1: sequential fetch, same-cycle ack, wraps past FF.
    do_reset();
    for (int i = 0; i < 260; i++) begin
      xact(0, 0, 0, 2'd0, 8'h00, 8'h00);
      if (i == 255) check_eq("wrap_to_00", imem_addr, 8'h00);
    end

    // 2: branch at 10 with offset -4.
    do_reset();
    xact(0, 0, 1, 2'd1, 8'h10, 8'h00);
    xact(0, 0, 1, 2'd0, 8'hFC, 8'h00);
    check_eq("branch_0C", imem_addr, 8'h0C);

    // 3: jal at 05 then jr back to 06.
    do_reset();
    xact(0, 0, 1, 2'd1, 8'h05, 8'h00);
    xact(0, 0, 1, 2'd2, 8'h03, 8'h00);
    check_eq("jal_08", imem_addr, 8'h08);
    xact(0, 0, 1, 2'd3, 8'h00, 8'h06);
    check_eq("jr_06", imem_addr, 8'h06);

    // 4: slow memory and stalled decode.
    xact(3, 2, 0, 2'd0, 8'h00, 8'h00);
    xact(3, 2, 0, 2'd0, 8'h00, 8'h00);
    check_eq("slow_seq", imem_addr, 8'h08);

    // 5: halt paths and reset mid-fetch.
    halt_in_req();
    xact(1, 0, 0, 2'd0, 8'h00, 8'h00);
    halt_in_hold();
    xact(0, 1, 0, 2'd0, 8'h00, 8'h00);
    wait_req();
    do_reset();
    halt = 1;
    step();
    check_eq("idle_to_halt", {halted, imem_req}, 2'b10);
    halt = 0;
    step();
    check_eq("halt_exit_pc", {imem_req, imem_addr}, {1'b1, 8'h00});

    // 6: nested jals beyond RAS depth, then unwinding jrs.
    do_reset();
    for (int i = 0; i < 5; i++) xact(0, 0, 1, 2'd2, 8'h01, 8'h00);
`ifdef PC_RAS_EN
    exp_jr = '{8'h05, 8'h04, 8'h03, 8'h02, 8'hEE};
`else
    exp_jr = '{8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE};
`endif
    for (int i = 0; i < 5; i++) begin
      xact(0, 0, 1, 2'd3, 8'h00, 8'hEE);
      check_eq("jr_unwind", imem_addr, exp_jr[i]);
    end

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int r = $urandom_range(0, 19);
      if (r == 0) halt_in_req();
      else if (r == 1) halt_in_hold();
      else xact($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 2'($urandom),
                8'($urandom), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
